// File: rtl/mcu_boot_ctrl_if.sv
// mcu_boot_ctrl_if: host download link, a valid/ready byte stream with start and last markers
interface mcu_boot_ctrl_if;
  logic       dl_start;
  logic       dl_valid;
  logic [7:0] dl_data;
  logic       dl_last;
  logic       dl_ready;
  modport master (output dl_start, dl_valid, dl_data, dl_last, input dl_ready);
  modport slave (input dl_start, dl_valid, dl_data, dl_last, output dl_ready);
endinterface

// File: rtl/mcu_boot_ctrl.sv
// mcu_boot_ctrl: loads a program image into ROM, holds the MCU in reset, then hands the ROM port to fetch
module mcu_boot_ctrl #(
  parameter int ROM_AW   = 11,
  parameter int HOLD_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  mcu_boot_ctrl_if.slave    dl,
  input  logic [ROM_AW-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_wdata,
  output logic              rom_we,
  input  logic [7:0]        rom_rdata,
  output logic              mcu_reset,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum,
  output logic [ROM_AW:0]   byte_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYC - 1);
  state_t            state_q, state_d;
  logic [ROM_AW:0]   cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d, hold_q, hold_d, wdata_q, wdata_d;
  logic [ROM_AW-1:0] waddr_q, waddr_d;
  logic              we_q, we_d, mrst_q, mrst_d, busy_q, busy_d, done_q, done_d;
  logic              acc, fin;
  assign dl.dl_ready = state_q == LOAD;
  assign rom_addr    = state_q == RUN ? cpu_addr : waddr_q;
  assign cpu_data    = state_q == RUN ? rom_rdata : 8'h00;
  assign rom_wdata   = wdata_q;
  assign rom_we      = we_q;
  assign mcu_reset   = mrst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign checksum    = sum_q;
  assign byte_cnt    = cnt_q;
  always_comb begin
    acc     = dl.dl_valid & (state_q == LOAD);
    // the byte count doubles as write pointer; all-ones low bits means this accept fills the ROM
    fin     = acc & (dl.dl_last | (&cnt_q[ROM_AW-1:0]));
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    hold_d  = hold_q;
    we_d    = acc & ~dl.dl_start;
    waddr_d = we_d ? cnt_q[ROM_AW-1:0] : waddr_q;
    wdata_d = we_d ? dl.dl_data : wdata_q;
    if (dl.dl_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (acc) begin
      cnt_d   = cnt_q + 1'b1;
      sum_d   = sum_q + dl.dl_data;
      state_d = fin ? HOLD : LOAD;
      hold_d  = fin ? HOLD_INIT : hold_q;
    end else if (state_q == HOLD) begin
      state_d = hold_q == 8'd0 ? RUN : HOLD;
      hold_d  = hold_q == 8'd0 ? hold_q : hold_q - 8'd1;
    end
    mrst_d = state_d != RUN;
    busy_d = state_d == LOAD || state_d == HOLD;
    done_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      mrst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      mrst_q  <= mrst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/mcu_boot_ctrl.md
Name: mcu_boot_ctrl

Overview:
- Boot/download controller that owns the MCU program ROM port.
- Holds the MCU in reset while a host streams a program image into ROM over a valid/ready byte interface.
- After the load, runs a fixed reset-hold delay, then releases the MCU and hands the ROM read port to CPU fetch.
- Sits between the host download link, the 2048x8 program ROM (synchronous BRAM) and the MCU `reset` / fetch-address pins.

Parameters:
- ROM_AW, 11, ROM address width; image capacity is 2^ROM_AW bytes.
- HOLD_CYC, 16, clk cycles `mcu_reset` stays high after the load completes (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- dl_start  in  1  one-cycle pulse; begins or restarts a download
- dl_valid  in  1  host byte valid
- dl_data  in  8  host byte
- dl_last  in  1  marks final byte; qualified by dl_valid & dl_ready
- dl_ready  out  1  controller accepts byte this cycle
- cpu_addr  in  ROM_AW  MCU fetch address
- cpu_data  out  8  fetch data to MCU
- rom_addr  out  ROM_AW  ROM address
- rom_wdata  out  8  ROM write data
- rom_we  out  1  ROM write enable, active-high
- rom_rdata  in  8  ROM read data, valid 1 cycle after rom_addr
- mcu_reset  out  1  MCU reset, active-high
- busy  out  1  high in LOAD or HOLD
- done  out  1  high in RUN
- checksum  out  8  mod-256 sum of bytes accepted in the current/last load
- byte_cnt  out  ROM_AW+1  bytes accepted in the current/last load

Behaviour:
- Reset values:
  - state=IDLE, mcu_reset=1, dl_ready=0, rom_we=0, rom_addr=0, rom_wdata=0
  - cpu_data=0, busy=0, done=0, checksum=0, byte_cnt=0, hold counter=0
- States: IDLE, LOAD, HOLD, RUN.
- IDLE:
  - mcu_reset=1, dl_ready=0.
  - dl_start -> LOAD; wptr, byte_cnt and checksum cleared in the same edge.
- LOAD:
  - dl_ready=1 combinationally while in LOAD.
  - Accept = dl_valid & dl_ready.
  - On accept, at the next edge: rom_we=1, rom_addr=wptr, rom_wdata=dl_data (registered, 1-cycle write latency); wptr+=1; byte_cnt+=1; checksum+=dl_data (8-bit wrap).
  - rom_we=0 in any cycle without an accept.
  - Load ends on an accepted byte with dl_last=1, or on the accept that makes byte_cnt=2^ROM_AW, whichever comes first. Transition -> HOLD at that edge; the final write still issues.
  - Bytes beyond capacity are never accepted; wptr does not wrap.
  - dl_start during LOAD restarts: wptr, byte_cnt and checksum cleared, stay in LOAD; a byte accepted in the same cycle is dropped.
  - dl_valid=0 stalls indefinitely; there is no timeout.
- HOLD:
  - mcu_reset=1, dl_ready=0; hold counter loads HOLD_CYC-1 on entry and decrements each cycle.
  - At 0 -> RUN. mcu_reset falls exactly HOLD_CYC cycles after the edge that entered HOLD.
  - dl_start -> LOAD (restart).
- RUN:
  - mcu_reset=0, done=1, dl_ready=0.
  - rom_addr=cpu_addr combinationally; cpu_data=rom_rdata (1-cycle synchronous read, as for the existing BRAM fetch).
  - cpu_data=8'h00 in all other states.
  - dl_start -> LOAD: mcu_reset=1 from the same edge, done=0, counters cleared.
- Outside RUN, rom_addr is driven from the write path only; CPU fetches never reach the ROM.
- busy = (state==LOAD | state==HOLD).
- Simultaneous events: reset overrides everything, including dl_start. dl_start overrides dl_last/full completion in the same cycle (restart wins).
- Reset mid-LOAD: ROM contents already written are retained; controller returns to IDLE and the MCU stays in reset.

Test Plan:
- Reset, then 4 bytes 0x15,0x80,0xAA,0xFF with dl_last on the 4th -> ROM[0..3] equal the bytes, byte_cnt=4, checksum=0x3E, mcu_reset falls 16 cycles after the 4th accept, done=1.
- Full image of 2048 bytes (data=addr[7:0]), no dl_last -> HOLD entered on byte 2048, dl_ready=0 afterwards, a 2049th valid byte is not accepted, checksum=0x00.
- RUN with cpu_addr=0x002 -> cpu_data=0xAA one cycle later; cpu_addr change during HOLD -> cpu_data stays 0x00.
- dl_valid toggling 1/0 every cycle for 6 bytes -> exactly 6 rom_we pulses, consecutive addresses 0..5, no duplicate writes.
- dl_start after 3 bytes of a load, then 2 new bytes with dl_last -> byte_cnt=2, checksum equals the sum of the 2 new bytes, writes restart at address 0.
- dl_start while in RUN -> mcu_reset=1 at the next edge, done=0; reset asserted mid-LOAD -> IDLE, dl_ready=0, mcu_reset=1.
